// File: rtl/port_gpio_irq_if.sv
// Register-access bus between the core datapath and the GPIO port block.
interface port_gpio_irq_if #(
  parameter int W  = 8,
  parameter int AW = 2
);
  logic [W-1:0]  dane;
  logic [AW-1:0] nr_port;
  logic [2:0]    reg_sel;
  logic          wr;
  logic [W-1:0]  out;
  logic          irq;

  modport master (
    output dane, nr_port, reg_sel, wr,
    input  out, irq
  );

  modport slave (
    input  dane, nr_port, reg_sel, wr,
    output out, irq
  );
endinterface

// File: rtl/port_gpio_irq.sv
// N x W GPIO port block: direction/output registers, synchronised read-back,
// atomic set/clear/toggle writes and masked per-bit edge interrupts.
module port_gpio_irq #(
  parameter int PORT_WIDTH = 8,
  parameter int PORT_COUNT = 3,
  parameter logic [PORT_COUNT-1:0] DDR_RST_MASK = 3'b100
) (
  input  logic                             clk,
  input  logic                             rst,
  port_gpio_irq_if.slave                   bus,
  inout  wire [PORT_COUNT*PORT_WIDTH-1:0]  pins
);
  localparam int W  = PORT_WIDTH;
  localparam int N  = PORT_COUNT;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] R_DDR  = 3'd0;
  localparam logic [2:0] R_PORT = 3'd1;
  localparam logic [2:0] R_PIN  = 3'd2;
  localparam logic [2:0] R_SET  = 3'd3;
  localparam logic [2:0] R_CLR  = 3'd4;
  localparam logic [2:0] R_IMSK = 3'd5;
  localparam logic [2:0] R_IFLG = 3'd6;
  localparam logic [2:0] R_IEDG = 3'd7;

  typedef logic [W-1:0] word_t;

  word_t ddr_q  [N];
  word_t ddr_d  [N];
  word_t port_q [N];
  word_t port_d [N];
  word_t imsk_q [N];
  word_t imsk_d [N];
  word_t iflg_q [N];
  word_t iflg_d [N];
  word_t iedg_q [N];
  word_t iedg_d [N];
  word_t s1_q   [N];
  word_t s1_d   [N];
  word_t s2_q   [N];
  word_t s2_d   [N];
  word_t prev_q [N];
  word_t prev_d [N];
  word_t ev     [N];

  logic [1:0] arm_q;
  logic [1:0] arm_d;
  logic       armed;

  assign armed = (arm_q == 2'd3);

  for (genvar p = 0; p < N; p++) begin : g_port
    for (genvar b = 0; b < W; b++) begin : g_bit
      assign pins[p*W+b] = ddr_q[p][b] ? port_q[p][b] : 1'bz;
    end
  end

  always_comb begin
    arm_d = armed ? arm_q : arm_q + 2'd1;
    for (int p = 0; p < N; p++) begin
      ddr_d[p]  = ddr_q[p];
      port_d[p] = port_q[p];
      imsk_d[p] = imsk_q[p];
      iflg_d[p] = iflg_q[p];
      iedg_d[p] = iedg_q[p];
      s1_d[p]   = pins[p*W +: W];
      s2_d[p]   = s1_q[p];
      prev_d[p] = s2_q[p];
      if (bus.wr && bus.nr_port == AW'(p)) begin
        case (bus.reg_sel)
          R_DDR:   ddr_d[p]  = bus.dane;
          R_PORT:  port_d[p] = bus.dane;
          R_PIN:   port_d[p] = port_q[p] ^ bus.dane;
          R_SET:   port_d[p] = port_q[p] | bus.dane;
          R_CLR:   port_d[p] = port_q[p] & ~bus.dane;
          R_IMSK:  imsk_d[p] = bus.dane;
          R_IFLG:  iflg_d[p] = iflg_q[p] & ~bus.dane;
          default: iedg_d[p] = bus.dane;
        endcase
      end
      // Events are applied after the W1C so a coincident edge keeps the flag.
      ev[p] = ~ddr_q[p] & {W{armed}} &
              ((iedg_q[p] & s2_q[p] & ~prev_q[p]) |
               (~iedg_q[p] & ~s2_q[p] & prev_q[p]));
      iflg_d[p] = iflg_d[p] | ev[p];
    end
  end

  always_comb begin
    bus.out = '0;
    for (int p = 0; p < N; p++) begin
      if (bus.nr_port == AW'(p)) begin
        case (bus.reg_sel)
          R_DDR:   bus.out = ddr_q[p];
          R_PORT:  bus.out = port_q[p];
          R_PIN:   bus.out = (ddr_q[p] & port_q[p]) |
                             (~ddr_q[p] & s2_q[p]);
          R_IMSK:  bus.out = imsk_q[p];
          R_IFLG:  bus.out = iflg_q[p];
          R_IEDG:  bus.out = iedg_q[p];
          default: bus.out = '0;
        endcase
      end
    end
  end

  always_comb begin
    bus.irq = 1'b0;
    for (int p = 0; p < N; p++) begin
      bus.irq = bus.irq | (|(iflg_q[p] & imsk_q[p]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q <= '0;
      for (int p = 0; p < N; p++) begin
        ddr_q[p]  <= {W{DDR_RST_MASK[p]}};
        port_q[p] <= '0;
        imsk_q[p] <= '0;
        iflg_q[p] <= '0;
        iedg_q[p] <= '0;
        s1_q[p]   <= '0;
        s2_q[p]   <= '0;
        prev_q[p] <= '0;
      end
    end else begin
      arm_q <= arm_d;
      for (int p = 0; p < N; p++) begin
        ddr_q[p]  <= ddr_d[p];
        port_q[p] <= port_d[p];
        imsk_q[p] <= imsk_d[p];
        iflg_q[p] <= iflg_d[p];
        iedg_q[p] <= iedg_d[p];
        s1_q[p]   <= s1_d[p];
        s2_q[p]   <= s2_d[p];
        prev_q[p] <= prev_d[p];
      end
    end
  end
endmodule

// File: tb/tb_port_gpio_irq.sv
// Directed bench for port_gpio_irq: register table plus edge/irq sequences.
module tb_port_gpio_irq;
  localparam int W  = 8;
  localparam int N  = 3;
  localparam int AW = 2;

  localparam logic [2:0] DDR  = 3'd0;
  localparam logic [2:0] PRT  = 3'd1;
  localparam logic [2:0] PIN  = 3'd2;
  localparam logic [2:0] SET  = 3'd3;
  localparam logic [2:0] CLR  = 3'd4;
  localparam logic [2:0] IMSK = 3'd5;
  localparam logic [2:0] IFLG = 3'd6;
  localparam logic [2:0] IEDG = 3'd7;

  typedef struct {
    logic       wr;
    logic [1:0] port;
    logic [2:0] sel;
    logic [7:0] dane;
    logic [7:0] exp_out;
    logic [7:0] exp_pad;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] pad_en;
  logic [15:0] pad_val;
  wire  [N*W-1:0] pins;
  int checks = 0;
  int fails  = 0;
  vec_t tv [26];

  port_gpio_irq_if #(.W(W), .AW(AW)) bus ();

  port_gpio_irq #(
    .PORT_WIDTH  (W),
    .PORT_COUNT  (N),
    .DDR_RST_MASK(3'b100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .pins(pins)
  );

  for (genvar i = 0; i < 16; i++) begin : g_pad
    assign pins[i] = pad_en[i] ? pad_val[i] : 1'bz;
  end

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] p,
                       input logic [2:0] s, input logic [7:0] d);
    bus.wr      = w;
    bus.nr_port = p;
    bus.reg_sel = s;
    bus.dane    = d;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] irq8();
    return {7'b0, bus.irq};
  endfunction

  initial begin
    tv[0]  = '{1'b1, 2'd0, IEDG, 8'hFF, 8'h00, 8'h00};
    tv[1]  = '{1'b0, 2'd0, IFLG, 8'h00, 8'h00, 8'h00};
    tv[2]  = '{1'b0, 2'd0, IFLG, 8'h00, 8'h00, 8'h00};
    tv[3]  = '{1'b0, 2'd0, IFLG, 8'h00, 8'h00, 8'h00};
    tv[4]  = '{1'b1, 2'd3, DDR,  8'hFF, 8'h00, 8'h00};
    tv[5]  = '{1'b0, 2'd3, DDR,  8'h00, 8'h00, 8'h00};
    tv[6]  = '{1'b0, 2'd0, IFLG, 8'h00, 8'h00, 8'h00};
    tv[7]  = '{1'b0, 2'd0, PIN,  8'h00, 8'hFF, 8'h00};
    tv[8]  = '{1'b0, 2'd0, IEDG, 8'h00, 8'hFF, 8'h00};
    tv[9]  = '{1'b0, 2'd0, DDR,  8'h00, 8'h00, 8'h00};
    tv[10] = '{1'b0, 2'd1, DDR,  8'h00, 8'h00, 8'h00};
    tv[11] = '{1'b1, 2'd2, PRT,  8'h0F, 8'h00, 8'h00};
    tv[12] = '{1'b0, 2'd2, PRT,  8'h00, 8'h0F, 8'h0F};
    tv[13] = '{1'b1, 2'd2, SET,  8'hF0, 8'h00, 8'h0F};
    tv[14] = '{1'b0, 2'd2, PRT,  8'h00, 8'hFF, 8'hFF};
    tv[15] = '{1'b1, 2'd2, CLR,  8'h81, 8'h00, 8'hFF};
    tv[16] = '{1'b0, 2'd2, PRT,  8'h00, 8'h7E, 8'h7E};
    tv[17] = '{1'b1, 2'd2, PIN,  8'hFF, 8'h7E, 8'h7E};
    tv[18] = '{1'b0, 2'd2, PRT,  8'h00, 8'h81, 8'h81};
    tv[19] = '{1'b0, 2'd2, PIN,  8'h00, 8'h81, 8'h81};
    tv[20] = '{1'b0, 2'd2, SET,  8'h00, 8'h00, 8'h81};
    tv[21] = '{1'b0, 2'd2, CLR,  8'h00, 8'h00, 8'h81};
    tv[22] = '{1'b1, 2'd1, IEDG, 8'hFF, 8'h00, 8'h81};
    tv[23] = '{1'b1, 2'd1, IMSK, 8'h01, 8'h00, 8'h81};
    tv[24] = '{1'b0, 2'd1, IEDG, 8'h00, 8'hFF, 8'h81};
    tv[25] = '{1'b0, 2'd1, IMSK, 8'h00, 8'h01, 8'h81};

    pad_en  = 16'hFFFF;
    pad_val = 16'h00FF;
    drive(1'b0, 2'd2, DDR, 8'h00);

    // Reset state, port 0 pad held high throughout.
    repeat (2) @(negedge clk);
    drive(1'b0, 2'd2, DDR, 8'h00);
    chk("rst ddr2", bus.out, 8'hFF);
    chk("rst pad2", pins[23:16], 8'h00);
    chk("rst irq", irq8(), 8'h00);
    drive(1'b0, 2'd0, DDR, 8'h00);
    chk("rst ddr0", bus.out, 8'h00);
    drive(1'b0, 2'd1, DDR, 8'h00);
    chk("rst ddr1", bus.out, 8'h00);
    drive(1'b0, 2'd2, PRT, 8'h00);
    chk("rst port2", bus.out, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      drive(tv[i].wr, tv[i].port, tv[i].sel, tv[i].dane);
      chk($sformatf("vec%0d out", i), bus.out, tv[i].exp_out);
      chk($sformatf("vec%0d pad2", i), pins[23:16], tv[i].exp_pad);
      chk($sformatf("vec%0d irq", i), irq8(), 8'h00);
      @(negedge clk);
    end

    // Port 0: falls ignored under IEDG=1, then 0x00->0xA5 through sync.
    pad_val[7:0] = 8'h00;
    drive(1'b0, 2'd0, IFLG, 8'h00);
    step(); step(); step();
    chk("p0 fall ignored", bus.out, 8'h00);
    pad_val[7:0] = 8'hA5;
    drive(1'b0, 2'd0, PIN, 8'h00);
    chk("p0 pin pre", bus.out, 8'h00);
    step();
    chk("p0 pin k", bus.out, 8'h00);
    step();
    chk("p0 pin k+1", bus.out, 8'hA5);
    drive(1'b0, 2'd0, IFLG, 8'h00);
    chk("p0 iflg k+1", bus.out, 8'h00);
    step();
    chk("p0 iflg k+2", bus.out, 8'hA5);
    chk("p0 irq masked", irq8(), 8'h00);
    drive(1'b1, 2'd0, IFLG, 8'hFF);
    step();
    drive(1'b0, 2'd0, IFLG, 8'h00);
    chk("p0 iflg w1c", bus.out, 8'h00);

    // Port 1 bit0 rising, masked in.
    pad_val[15:8] = 8'h01;
    drive(1'b0, 2'd1, IFLG, 8'h00);
    chk("p1 iflg pre", bus.out, 8'h00);
    step();
    chk("p1 irq k", irq8(), 8'h00);
    step();
    chk("p1 irq k+1", irq8(), 8'h00);
    step();
    chk("p1 irq k+2", irq8(), 8'h01);
    chk("p1 iflg k+2", bus.out, 8'h01);
    drive(1'b1, 2'd1, IFLG, 8'h01);
    chk("p1 irq pre w1c", irq8(), 8'h01);
    step();
    drive(1'b0, 2'd1, IFLG, 8'h00);
    chk("p1 irq w1c", irq8(), 8'h00);
    chk("p1 iflg w1c", bus.out, 8'h00);

    // Port 1 bit1 rising, masked out; then unmask/remask.
    pad_val[15:8] = 8'h03;
    step(); step(); step();
    chk("p1 b1 iflg", bus.out, 8'h02);
    chk("p1 b1 irq", irq8(), 8'h00);
    drive(1'b1, 2'd1, IMSK, 8'h03);
    chk("imsk pre", irq8(), 8'h00);
    step();
    chk("imsk on", irq8(), 8'h01);
    drive(1'b1, 2'd1, IMSK, 8'h01);
    step();
    chk("imsk off", irq8(), 8'h00);
    drive(1'b1, 2'd1, IFLG, 8'h03);
    step();
    drive(1'b0, 2'd1, IFLG, 8'h00);
    chk("p1 clr all", bus.out, 8'h00);

    // Coincident W1C and new rising edge on bit0.
    pad_val[15:8] = 8'h02;
    step(); step(); step();
    chk("p1 b0 fall ign", bus.out, 8'h00);
    pad_val[15:8] = 8'h03;
    step();
    pad_val[15:8] = 8'h02;
    step();
    pad_val[15:8] = 8'h03;
    step();
    chk("coin irq k+2", irq8(), 8'h01);
    chk("coin iflg k+2", bus.out, 8'h01);
    step();
    drive(1'b1, 2'd1, IFLG, 8'h01);
    chk("coin irq k+3", irq8(), 8'h01);
    step();
    drive(1'b0, 2'd1, IFLG, 8'h00);
    chk("coin iflg", bus.out, 8'h01);
    chk("coin irq", irq8(), 8'h01);

    // Reset mid-operation drops the pending flag.
    rst = 1'b1;
    #1;
    chk("mid rst pre irq", irq8(), 8'h01);
    step();
    chk("mid rst irq", irq8(), 8'h00);
    chk("mid rst iflg", bus.out, 8'h00);
    drive(1'b0, 2'd2, DDR, 8'h00);
    chk("mid rst ddr2", bus.out, 8'hFF);
    drive(1'b0, 2'd1, IEDG, 8'h00);
    chk("mid rst iedg1", bus.out, 8'h00);
    chk("mid rst pad2", pins[23:16], 8'h00);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
